bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, system bus data/address width.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, system bus tag width.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum cycles in one tenure before the watchdog fires.
REQ-004 SHALL have one clock and reset is asynchronous and active-high, named as the codebase does: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-005 SHALL have icache_busreq  in  1  icache wants the bus; icache_busidle  in  1  icache tenure finished; icache_busgrant  out  1  icache owns bus.
REQ-006 SHALL have dcache_busreq  in  1; dcache_busidle  in  1; dcache_busgrant  out  1; same meanings for dcache.
REQ-007 SHALL have icache_reqcyc, icache_respack  in  1; icache_req  in  BUS_DATA_WIDTH; icache_reqtag  in  BUS_TAG_WIDTH; the icache request-side bus signals.
REQ-008 SHALL have dcache_reqcyc, dcache_respack  in  1; dcache_req  in  BUS_DATA_WIDTH; dcache_reqtag  in  BUS_TAG_WIDTH; the dcache request-side bus signals.
REQ-009 SHALL have bus_reqcyc, bus_respack  out  1; bus_req  out  BUS_DATA_WIDTH; bus_reqtag  out  BUS_TAG_WIDTH; the muxed system bus request side.
REQ-010 SHALL have err_timeout  out  1, sticky watchdog flag.

Function
REQ-011 SHALL implement states IDLE, GRANT_I, GRANT_D, RELEASE.
REQ-012 SHALL make icache_busgrant and dcache_busgrant registered outputs equal to (state==GRANT_I) and (state==GRANT_D); never both high.
REQ-013 SHALL in IDLE or RELEASE: only one busreq high -> that grant state next cycle; both high -> the client not granted last (last_owner register); neither -> IDLE.
REQ-014 SHALL set last_owner at every grant entry; reset value icache, so dcache wins the first simultaneous request.
REQ-015 SHALL give grant latency of exactly 1 cycle: busreq sampled high in IDLE at edge N -> busgrant high after edge N.
REQ-016 SHALL keep a 16-bit tenure counter, cleared on grant entry, incremented each granted cycle, saturating.
REQ-017 SHALL leave GRANT_x for RELEASE when tenure counter >= 2 and x_busidle==1 and x_busreq==0 (the 2-cycle minimum covers client busreq/busidle update lag).
REQ-018 SHALL also leave GRANT_x for RELEASE when tenure counter reaches TIMEOUT-1, setting err_timeout=1.
REQ-019 SHALL hold err_timeout until reset.
REQ-020 SHALL keep RELEASE one cycle, grants low; arbitration per REQ-013 happens in RELEASE, so back-to-back handover costs one dead cycle.
REQ-021 SHALL drive bus_* combinationally from the granted client's signals in GRANT_I/GRANT_D, and all zero in IDLE and RELEASE.
REQ-022 SHALL ignore busreq of the non-owner during a tenure; that request is served at the next RELEASE/IDLE evaluation.
REQ-023 SHALL not route or filter bus_resp/bus_respcyc/bus_resptag; clients observe responses (incl. invalidation tag 12'h800) directly.
REQ-024 SHALL treat busidle of a non-owner as don't-care.

Reset
REQ-025 SHALL on reset assertion, at any time including mid-tenure, immediately: state=IDLE, both grants 0, bus_* 0, last_owner=icache, tenure counter 0, err_timeout 0.
REQ-026 SHALL resume arbitration on the first rising edge after reset deassertion.

Verification
REQ-027 SHALL cover: reset, then dcache_busreq=1 at edge 1 -> dcache_busgrant=1 after edge 1, bus_req mirrors dcache_req=64'h1000.
REQ-028 SHALL cover: both busreq=1 after reset -> dcache granted first; after dcache busreq=0, busidle=1 -> RELEASE 1 cycle -> icache granted; bus_* zero during RELEASE.
REQ-029 SHALL cover: dcache owner holds busidle=0 for TIMEOUT=16 -> forced RELEASE at tenure cycle 15, err_timeout=1 and sticky through later tenures.
REQ-030 SHALL cover: icache owner raises busidle=1 at tenure cycle 0 -> no release before counter=2.
REQ-031 SHALL cover: reset asserted mid dcache tenure, between edges -> grant and bus_reqcyc drop without waiting for clk.
REQ-032 SHALL cover: random busreq/busidle traffic 10k cycles -> grants mutually exclusive, no starvation (each requester granted within 2 tenures).

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Request-side bus bundle shared between the icache/dcache clients and the arbiter.
// The arbiter takes the master view; the client/bench side takes the slave view.
interface bus_arbiter_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      icache_busreq, icache_busidle, icache_busgrant;
  logic                      dcache_busreq, dcache_busidle, dcache_busgrant;
  logic                      icache_reqcyc, icache_respack;
  logic [BUS_DATA_WIDTH-1:0] icache_req;
  logic [BUS_TAG_WIDTH-1:0]  icache_reqtag;
  logic                      dcache_reqcyc, dcache_respack;
  logic [BUS_DATA_WIDTH-1:0] dcache_req;
  logic [BUS_TAG_WIDTH-1:0]  dcache_reqtag;
  logic                      bus_reqcyc, bus_respack;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;

  modport master (
    input  icache_busreq, icache_busidle, dcache_busreq, dcache_busidle,
    input  icache_reqcyc, icache_respack, icache_req, icache_reqtag,
    input  dcache_reqcyc, dcache_respack, dcache_req, dcache_reqtag,
    output icache_busgrant, dcache_busgrant,
    output bus_reqcyc, bus_respack, bus_req, bus_reqtag
  );

  modport slave (
    output icache_busreq, icache_busidle, dcache_busreq, dcache_busidle,
    output icache_reqcyc, icache_respack, icache_req, icache_reqtag,
    output dcache_reqcyc, dcache_respack, dcache_req, dcache_reqtag,
    input  icache_busgrant, dcache_busgrant,
    input  bus_reqcyc, bus_respack, bus_req, bus_reqtag
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-client (icache/dcache) system bus arbiter: alternating priority on contention,
// minimum two-cycle tenure, one dead RELEASE cycle per handover, sticky tenure watchdog.
module bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int TIMEOUT        = 1024
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.master arb,
  output logic          err_timeout
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_n;
  logic        last_d;   // 1 when dcache held the most recent grant
  logic [15:0] tenure;
  logic        granted, enter, timeout_hit;

  assign granted     = (state == GRANT_I) || (state == GRANT_D);
  assign enter       = !granted && (state_n == GRANT_I || state_n == GRANT_D);
  assign timeout_hit = granted && (tenure >= TO_LAST);

  always_comb begin
    state_n = state;
    case (state)
      IDLE, RELEASE: begin
        if (arb.icache_busreq && arb.dcache_busreq) state_n = last_d ? GRANT_I : GRANT_D;
        else if (arb.icache_busreq)                 state_n = GRANT_I;
        else if (arb.dcache_busreq)                 state_n = GRANT_D;
        else                                        state_n = IDLE;
      end
      // The two-cycle floor hides the client's lag in updating busreq/busidle.
      GRANT_I: if (timeout_hit ||
                   (tenure >= 16'd2 && arb.icache_busidle && !arb.icache_busreq))
                 state_n = RELEASE;
      GRANT_D: if (timeout_hit ||
                   (tenure >= 16'd2 && arb.dcache_busidle && !arb.dcache_busreq))
                 state_n = RELEASE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      tenure      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      if (enter) begin
        last_d <= (state_n == GRANT_D);
        tenure <= '0;
      end else if (granted && tenure != 16'hFFFF) begin
        tenure <= tenure + 16'd1;
      end
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

  logic                      reqcyc_mux, respack_mux;
  logic [BUS_DATA_WIDTH-1:0] req_mux;
  logic [BUS_TAG_WIDTH-1:0]  tag_mux;

  always_comb begin
    reqcyc_mux  = 1'b0;
    respack_mux = 1'b0;
    req_mux     = '0;
    tag_mux     = '0;
    case (state)
      GRANT_I: begin
        reqcyc_mux  = arb.icache_reqcyc;
        respack_mux = arb.icache_respack;
        req_mux     = arb.icache_req;
        tag_mux     = arb.icache_reqtag;
      end
      GRANT_D: begin
        reqcyc_mux  = arb.dcache_reqcyc;
        respack_mux = arb.dcache_respack;
        req_mux     = arb.dcache_req;
        tag_mux     = arb.dcache_reqtag;
      end
      default: ;
    endcase
  end

  assign arb.icache_busgrant = (state == GRANT_I);
  assign arb.dcache_busgrant = (state == GRANT_D);
  assign arb.bus_reqcyc      = reqcyc_mux;
  assign arb.bus_respack     = respack_mux;
  assign arb.bus_req         = req_mux;
  assign arb.bus_reqtag      = tag_mux;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector table plus hand sequences (watchdog, async reset) and random traffic
// for bus_arbiter.
module tb_bus_arbiter;
  localparam int DW = 64;
  localparam int TW = 13;
  localparam int TO = 16;
  localparam logic [DW-1:0] I_REQ = 64'h2000;
  localparam logic [DW-1:0] D_REQ = 64'h1000;
  localparam logic [TW-1:0] I_TAG = 13'h011;
  localparam logic [TW-1:0] D_TAG = 13'h800;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_timeout;
  int   n_chk = 0;
  int   n_pass = 0;

  bus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) ifc ();

  bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .arb         (ifc.master),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst, ir, ii, dr, di;
    logic gi, gd, err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_out(input string name, input logic gi, input logic gd, input logic e);
    logic [DW-1:0] ereq;
    logic [14:0]   ectl;
    ereq = gd ? D_REQ : gi ? I_REQ : '0;
    ectl = gd ? {1'b1, 1'b0, D_TAG} : gi ? {1'b1, 1'b1, I_TAG} : 15'd0;
    chk({name, ".grant"}, 64'({ifc.icache_busgrant, ifc.dcache_busgrant}), 64'({gi, gd}));
    chk({name, ".err"}, 64'(err_timeout), 64'(e));
    chk({name, ".bus_req"}, ifc.bus_req, ereq);
    chk({name, ".bus_ctl"}, 64'({ifc.bus_reqcyc, ifc.bus_respack, ifc.bus_reqtag}), 64'(ectl));
  endtask

  task automatic step(input logic r, input logic ir, input logic ii, input logic dr, input logic di);
    reset = r;
    ifc.icache_busreq  = ir;
    ifc.icache_busidle = ii;
    ifc.dcache_busreq  = dr;
    ifc.dcache_busidle = di;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [29];

  initial begin
    int   wait_i, wait_d, max_wait, excl_bad, n_gi, n_gd;
    logic ir, dr, gi_prev, gd_prev;

    ifc.icache_busreq  = 1'b0; ifc.icache_busidle = 1'b0;
    ifc.dcache_busreq  = 1'b0; ifc.dcache_busidle = 1'b0;
    ifc.icache_reqcyc  = 1'b1; ifc.icache_respack = 1'b1;
    ifc.icache_req     = I_REQ; ifc.icache_reqtag = I_TAG;
    ifc.dcache_reqcyc  = 1'b1; ifc.dcache_respack = 1'b0;
    ifc.dcache_req     = D_REQ; ifc.dcache_reqtag = D_TAG;

    //        rst ir ii dr di  gi gd err
    vecs = '{
      8'b1_0_0_0_0_0_0_0,  // reset state
      8'b0_0_0_1_0_0_1_0,  // dcache alone: 1-cycle grant
      8'b0_0_0_0_1_0_1_0,  // idle at tenure 0: hold
      8'b0_0_0_0_1_0_1_0,  // tenure 1: hold
      8'b0_0_0_0_1_0_0_0,  // tenure 2: RELEASE
      8'b0_0_0_0_0_0_0_0,  // back to IDLE
      8'b0_1_0_1_0_1_0_0,  // contention, dcache was last -> icache
      8'b0_1_0_1_0_1_0_0,
      8'b0_0_1_1_0_1_0_0,
      8'b0_0_1_1_0_0_0_0,  // RELEASE dead cycle
      8'b0_0_1_1_0_0_1_0,  // pending dcache served from RELEASE
      8'b0_1_0_1_1_0_1_0,  // icache req ignored mid-tenure
      8'b0_1_0_0_1_0_1_0,
      8'b0_1_0_0_1_0_0_0,
      8'b0_1_0_0_1_1_0_0,
      8'b0_0_1_0_1_1_0_0,
      8'b0_0_1_0_1_1_0_0,
      8'b0_0_1_0_1_0_0_0,
      8'b0_0_0_0_0_0_0_0,
      8'b1_1_0_1_0_0_0_0,  // reset restores last_owner=icache
      8'b0_1_0_1_0_0_1_0,  // first contention -> dcache
      8'b0_1_0_0_1_0_1_0,
      8'b0_1_0_0_1_0_1_0,
      8'b0_1_0_0_1_0_0_0,  // RELEASE, bus zero
      8'b0_1_0_0_1_1_0_0,  // icache granted
      8'b0_0_1_0_1_1_0_0,  // idle at tenure 0: no early release
      8'b0_0_1_0_1_1_0_0,
      8'b0_0_1_0_1_0_0_0,
      8'b0_0_0_0_0_0_0_0
    };

    for (int i = 0; i < 29; i++) begin
      step(vecs[i].rst, vecs[i].ir, vecs[i].ii, vecs[i].dr, vecs[i].di);
      expect_out($sformatf("vec%0d", i), vecs[i].gi, vecs[i].gd, vecs[i].err);
    end

    // Watchdog: dcache never idles, forced out after TO granted cycles.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    expect_out("to_grant", 0, 1, 0);
    for (int i = 1; i < TO; i++) begin
      step(0, 0, 0, 1, 0);
      expect_out($sformatf("to_hold%0d", i), 0, 1, 0);
    end
    step(0, 0, 0, 1, 0);
    expect_out("to_fire", 0, 0, 1);
    step(0, 0, 0, 1, 0);
    expect_out("to_regrant", 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    expect_out("to_sticky", 0, 0, 1);

    // Async reset mid-tenure, between clock edges.
    step(0, 0, 0, 1, 0);
    expect_out("ar_grant", 0, 1, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    expect_out("ar_drop", 0, 0, 0);
    #1;
    reset = 1'b0;
    step(0, 0, 0, 1, 0);
    expect_out("ar_resume", 0, 1, 0);

    // Random traffic: exclusivity and bounded wait.
    step(1, 0, 1, 0, 1);
    ir = 1'b0; dr = 1'b0; gi_prev = 1'b0; gd_prev = 1'b0;
    wait_i = 0; wait_d = 0; max_wait = 0; excl_bad = 0; n_gi = 0; n_gd = 0;
    for (int c = 0; c < 10000; c++) begin
      if (ifc.icache_busgrant) begin
        if (ir && $urandom_range(3) == 0) ir = 1'b0;
      end else if (!ir && $urandom_range(2) == 0) ir = 1'b1;
      if (ifc.dcache_busgrant) begin
        if (dr && $urandom_range(3) == 0) dr = 1'b0;
      end else if (!dr && $urandom_range(2) == 0) dr = 1'b1;
      step(0, ir, !ir, dr, !dr);
      if (ifc.icache_busgrant && ifc.dcache_busgrant) excl_bad++;
      if (ifc.icache_busgrant && !gi_prev) n_gi++;
      if (ifc.dcache_busgrant && !gd_prev) n_gd++;
      if (ir && ifc.dcache_busgrant && !gd_prev) wait_i++;
      if (dr && ifc.icache_busgrant && !gi_prev) wait_d++;
      if (ifc.icache_busgrant) wait_i = 0;
      if (ifc.dcache_busgrant) wait_d = 0;
      if (wait_i > max_wait) max_wait = wait_i;
      if (wait_d > max_wait) max_wait = wait_d;
      gi_prev = ifc.icache_busgrant;
      gd_prev = ifc.dcache_busgrant;
    end
    chk("rand_exclusive", 64'(excl_bad), 64'd0);
    chk("rand_starve", 64'(max_wait > 2), 64'd0);
    chk("rand_i_served", 64'(n_gi > 100), 64'd1);
    chk("rand_d_served", 64'(n_gd > 100), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
